vga_frame_receiver: RTL

Receiving end of the VGA link driven by the game's sync generator and RGB mux. It takes `hsync`, `vsync` and `rgb[11:0]` as the monitor sees them and recovers the pixel coordinate and colour of every active pixel. It also reports whether the incoming timing is locked and flags any timing deviation. It is used as an on-board loopback checker and as the capture front-end for the frame-compare bench.

---
 rtl/vga_frame_receiver_pkg.sv | 32 +++
 rtl/sync_edge_detect.sv | 34 +++
 rtl/vga_frame_receiver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_receiver_pkg.sv
// Shared VGA timing defaults, counter sizing and lock FSM encoding for the
// frame receiver.
package vga_frame_receiver_pkg;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CLK_DIV   = 4;

    // Width of the pixel/line position counters (covers totals up to 4095).
    localparam int unsigned CNT_W = 12;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    // H_TOTAL / V_TOTAL: display + front porch + sync + back porch.
    function automatic int unsigned calc_total(input int unsigned disp,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with an edge register; the edge outputs are aligned
// with the synchronised level.
module sync_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_fall_c,
    output logic o_rise_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level  = r_sync;
    assign o_fall_c = r_prev & ~r_sync;
    assign o_rise_c = ~r_prev & r_sync;

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA link receiver: recovers pixel coordinates and colour from hsync/vsync/rgb,
// tracks timing lock and counts timing deviations.
module vga_frame_receiver
    import vga_frame_receiver_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic        pix_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [7:0]  err_count
);

    localparam int unsigned H_TOTAL   = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL   = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned LINE_CLKS = H_TOTAL * CLK_DIV;
    localparam int unsigned HS_CLKS   = H_SYNC * CLK_DIV;
    localparam int unsigned H_START   = H_SYNC + H_BACK;
    localparam int unsigned H_END     = H_START + H_DISPLAY;
    localparam int unsigned V_START   = V_SYNC + V_BACK;
    localparam int unsigned V_END     = V_START + V_DISPLAY;
    localparam int unsigned PH_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TICK_PH   = CLK_DIV / 2;
    localparam int unsigned LC_W      = $clog2(LINE_CLKS + 2) + 1;

    logic              w_hs_level, w_hs_fall, w_hs_rise;
    logic              w_vs_level, w_vs_fall, w_vs_rise;
    logic              w_unused;
    logic [11:0]       r_rgb_meta, r_rgb_sync;
    logic [PH_W-1:0]   r_phase, w_phase;
    logic [CNT_W-1:0]  r_hcnt, w_hcnt, r_vcnt, w_vcnt;
    logic [LC_W-1:0]   r_line_clks, r_hs_low;
    logic              r_hs_seen;
    logic              w_tick, w_h_act, w_v_act, w_cap;
    logic              w_err_line, w_err_timeout, w_err_width, w_err_frame;
    logic              w_err_any, w_err;
    lock_state_e       r_state, w_state_nxt;
    logic              r_pix_valid, r_frame_start, r_locked, r_timing_err;
    logic [9:0]        r_x, r_y;
    logic [11:0]       r_rgb_out;
    logic [7:0]        r_err_count;

    sync_edge_detect #(.RST_VAL(1'b1)) u_hs_sync (
        .i_clk    (clk_100MHz),
        .i_rst    (reset),
        .i_d      (hsync),
        .o_level  (w_hs_level),
        .o_fall_c (w_hs_fall),
        .o_rise_c (w_hs_rise)
    );

    sync_edge_detect #(.RST_VAL(1'b1)) u_vs_sync (
        .i_clk    (clk_100MHz),
        .i_rst    (reset),
        .i_d      (vsync),
        .o_level  (w_vs_level),
        .o_fall_c (w_vs_fall),
        .o_rise_c (w_vs_rise)
    );

    assign w_unused = &{1'b0, w_vs_level, w_vs_rise};

    // rgb gets the same two-stage delay as the sync levels so they stay aligned.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_rgb_meta <= '0;
            r_rgb_sync <= '0;
        end else begin
            r_rgb_meta <= rgb_in;
            r_rgb_sync <= r_rgb_meta;
        end
    end

    assign w_phase = w_hs_fall ? '0 : r_phase;
    assign w_tick  = (w_phase == PH_W'(TICK_PH));
    assign w_hcnt  = w_hs_fall ? '0 : r_hcnt;
    assign w_vcnt  = w_vs_fall ? '0
                   : ((w_hs_fall && (r_vcnt != '1)) ? r_vcnt + 1'b1 : r_vcnt);
    assign w_h_act = (w_hcnt >= CNT_W'(H_START)) && (w_hcnt < CNT_W'(H_END));
    assign w_v_act = (w_vcnt >= CNT_W'(V_START)) && (w_vcnt < CNT_W'(V_END));
    assign w_cap   = w_tick && w_h_act && w_v_act && (r_state == ST_LOCKED);

    // A late line is flagged once by the timeout; its eventual hsync is not re-flagged.
    assign w_err_line    = w_hs_fall && r_hs_seen
                         && (r_line_clks != LC_W'(LINE_CLKS))
                         && (r_line_clks <= LC_W'(LINE_CLKS + 1));
    assign w_err_timeout = !w_hs_fall && r_hs_seen && (r_line_clks == LC_W'(LINE_CLKS + 1));
    assign w_err_width   = w_hs_rise && r_hs_seen && (r_hs_low != LC_W'(HS_CLKS));
    assign w_err_frame   = w_vs_fall && (r_vcnt != CNT_W'(V_TOTAL - 1));
    assign w_err_any     = w_err_line | w_err_timeout | w_err_width | w_err_frame;
    assign w_err         = w_err_any && (r_state != ST_SEARCH);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_phase     <= '0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_line_clks <= '0;
            r_hs_low    <= '0;
            r_hs_seen   <= 1'b0;
        end else begin
            r_phase <= (w_phase == PH_W'(CLK_DIV - 1)) ? '0 : w_phase + 1'b1;
            r_hcnt  <= (w_tick && (w_hcnt != '1)) ? w_hcnt + 1'b1 : w_hcnt;
            r_vcnt  <= w_vcnt;
            if (w_hs_fall) begin
                r_line_clks <= LC_W'(1);
                r_hs_low    <= LC_W'(1);
                r_hs_seen   <= 1'b1;
            end else begin
                if (r_line_clks != '1) r_line_clks <= r_line_clks + 1'b1;
                if (!w_hs_level && (r_hs_low != '1)) r_hs_low <= r_hs_low + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) r_state <= ST_SEARCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_SEARCH: if (w_vs_fall) w_state_nxt = ST_VERIFY;
            ST_VERIFY: begin
                if (w_err_any)      w_state_nxt = ST_SEARCH;
                else if (w_vs_fall) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: if (w_err_any) w_state_nxt = ST_SEARCH;
            default:   w_state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_pix_valid   <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_rgb_out     <= '0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_pix_valid   <= w_cap;
            r_frame_start <= w_vs_fall;
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_timing_err  <= w_err;
            if (w_cap) begin
                r_x       <= 10'(w_hcnt - CNT_W'(H_START));
                r_y       <= 10'(w_vcnt - CNT_W'(V_START));
                r_rgb_out <= r_rgb_sync;
            end
            if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 1'b1;
        end
    end

    assign pix_valid   = r_pix_valid;
    assign x           = r_x;
    assign y           = r_y;
    assign rgb_out     = r_rgb_out;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign timing_err  = r_timing_err;
    assign err_count   = r_err_count;

endmodule
